instr_byte_loader: RTL and testbench
====================================

Name: instr_byte_loader

Overview:
- Upstream front-end of CPU instruction memory.
- Samples the 8-bit serial instruction stream on `instr_i` (one byte per clock) and frames it with start marker 8'hFE and end marker 8'hFF.
- Assembles each 4 bytes into a 32-bit little-endian word, writes it to instruction memory, and releases the core (`core_run_o`) once loading completes.

Parameters:
- ADDR_W, 6, word-address width of instruction memory.
- DEPTH, 64, number of writable words; must be ≤ 2**ADDR_W.
- START_BYTE, 8'hFE, start-of-program marker.
- END_BYTE, 8'hFF, end-of-program marker.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_i  in  8  instruction byte stream, sampled every rising edge
- imem_we_o  out  1  instruction memory write strobe, one cycle per word
- imem_addr_o  out  ADDR_W  word address of current write
- imem_data_o  out  32  assembled word: first byte in [7:0], fourth byte in [31:24]
- word_cnt_o  out  ADDR_W+1  words written since last start marker
- overflow_o  out  1  sticky; set when a word arrives with memory already full
- loading_o  out  1  high in LOAD state
- core_run_o  out  1  high in DONE; CPU is held idle while low

Behaviour:
- Reset (async, any time, including mid-word or mid-load):
  - State goes to IDLE.
  - byte_idx=0, word_cnt_o=0, shift register=0.
  - imem_we_o=0, imem_addr_o=0, imem_data_o=0.
  - overflow_o=0, loading_o=0, core_run_o=0.
- States: IDLE, LOAD, DONE; 2-bit byte_idx is used in LOAD only.
- IDLE:
  - Bytes other than START_BYTE are ignored; the idle value 8'h00 is expected.
  - instr_i==START_BYTE goes to LOAD next cycle, clearing word_cnt_o, byte_idx and overflow_o.
  - The marker byte itself is not stored.
- LOAD:
  - When byte_idx==0 and instr_i==END_BYTE, go to DONE and discard the byte.
  - END_BYTE is legal as a terminator only here: an instruction whose low byte is 8'hFF is a reserved RISC-V long encoding and is never loaded.
  - Any other byte is stored into lane byte_idx of the shift register, and byte_idx increments modulo 4.
  - START_BYTE inside LOAD is ordinary data at every byte_idx.
  - END_BYTE at byte_idx 1..3 is ordinary data.
- Word write, on the edge that captures the byte at byte_idx==3:
  - imem_we_o=1 for exactly the following cycle.
  - imem_data_o = the full word, including the just-captured byte in [31:24].
  - imem_addr_o = word_cnt_o before the increment.
  - word_cnt_o increments in the same cycle.
  - Write latency: 1 cycle from the last byte being sampled to the strobe.
  - Back-to-back words produce strobes 4 cycles apart.
  - imem_data_o and imem_addr_o hold their last values when imem_we_o=0.
- Full memory:
  - If word_cnt_o==DEPTH when a 4th byte arrives, no strobe is issued, word_cnt_o saturates at DEPTH, and overflow_o sets.
  - Loading continues and still waits for END_BYTE.
- Partial word at end:
  - Cannot occur, since END_BYTE is recognised only at byte_idx 0.
  - If the stream stops mid-word, the block stays in LOAD indefinitely with no write.
- DONE:
  - core_run_o=1, loading_o=0.
  - word_cnt_o and overflow_o hold.
  - instr_i==START_BYTE re-arms: go to LOAD, drop core_run_o next cycle, clear word_cnt_o and overflow_o, and start writing at address 0 again.
  - All other bytes are ignored.
- Simultaneous events: reset dominates every input. Only one byte is sampled per cycle, so no other conflicts exist.
- Outputs are registered; there are no combinational paths from instr_i to any output.

Test Plan:
- Stream 00,00,FE,13,05,A0,00,FF:
  - Exactly one imem_we_o, 1 cycle after byte 00 (the 4th data byte) is sampled, with addr 0 and data 32'h00A00513.
  - Then core_run_o=1 and word_cnt_o=1.
- FE then 3 words (12 bytes) then FF:
  - Strobes 4 cycles apart at addr 0,1,2.
  - word_cnt_o=3, then DONE.
- FE, then bytes FF,FE,FF at byte_idx 0..2:
  - The first FF ends the load immediately with word_cnt_o=0.
  - Separately, for FE,13,FF,FE,00,FF: one word 32'h00FEFF13 is written, then DONE.
- FE plus 65 words plus FF with DEPTH=64:
  - 64 strobes at addr 0..63.
  - overflow_o=1, word_cnt_o=64, core_run_o=1.
- Reset asserted mid-word after FE,13,05:
  - All outputs zero immediately, without waiting for a clock edge; IDLE.
  - A following stream FE,AA,BB,CC,DD,FF writes 32'hDDCCBBAA to addr 0.
- From DONE (word_cnt_o=2):
  - A stray byte 8'h37 is ignored.
  - FE re-arms: core_run_o low next cycle, word_cnt_o=0, and the next word writes addr 0.

Source files
------------

// File: rtl/instr_byte_loader.sv
// Instruction byte loader: frames a serial byte stream between START/END
// markers, packs bytes little-endian into 32-bit words and writes them to
// instruction memory, then releases the core once the end marker arrives.
module instr_byte_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DEPTH      = 64,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [7:0]  END_BYTE   = 8'hFF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              overflow_o,
  output logic              loading_o,
  output logic              core_run_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE  = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [1:0]          r_byte_idx;
  // Only lanes 0..2 are held; lane 3 goes straight from instr_i into the word.
  logic [23:0]         r_shift;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic [ADDR_W:0]     r_word_cnt;
  logic                r_overflow;
  logic                r_loading;
  logic                r_core_run;

  logic                w_full;
  logic                w_is_end;
  logic [31:0]         w_word;

  assign w_full   = (r_word_cnt == L_FULL);
  assign w_is_end = (r_byte_idx == 2'd0) && (instr_i == END_BYTE);
  assign w_word   = {instr_i, r_shift};

  // Framing FSM, byte packing and memory write strobe generation.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
      r_loading  <= 1'b0;
      r_core_run <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (instr_i == START_BYTE) begin
            r_state    <= S_LOAD;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
            r_loading  <= 1'b1;
            r_core_run <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_is_end) begin
            r_state    <= S_DONE;
            r_loading  <= 1'b0;
            r_core_run <= 1'b1;
          end else begin
            case (r_byte_idx)
              2'd0:    r_shift[7:0]   <= instr_i;
              2'd1:    r_shift[15:8]  <= instr_i;
              2'd2:    r_shift[23:16] <= instr_i;
              default: ;
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              if (w_full) begin
                r_overflow <= 1'b1;
              end else begin
                r_we       <= 1'b1;
                r_addr     <= r_word_cnt[ADDR_W-1:0];
                r_data     <= w_word;
                r_word_cnt <= r_word_cnt + L_ONE;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_we_o   = r_we;
  assign imem_addr_o = r_addr;
  assign imem_data_o = r_data;
  assign word_cnt_o  = r_word_cnt;
  assign overflow_o  = r_overflow;
  assign loading_o   = r_loading;
  assign core_run_o  = r_core_run;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Self-checking bench for instr_byte_loader: per-cycle vector table plus
// hand-written sequences, with a scoreboard of expected memory writes.
module tb_instr_byte_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic              clk_i = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        instr_i = 8'h00;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              overflow_o;
  logic              loading_o;
  logic              core_run_o;

  instr_byte_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .START_BYTE(8'hFE),
    .END_BYTE(8'hFF)
  ) dut (
    .clk_i(clk_i),
    .reset(reset),
    .instr_i(instr_i),
    .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o),
    .word_cnt_o(word_cnt_o),
    .overflow_o(overflow_o),
    .loading_o(loading_o),
    .core_run_o(core_run_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard of expected writes: {addr, data}
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t sb[$];

  // Reference model of the framing behaviour, advanced as each byte is driven
  typedef enum int {M_IDLE, M_LOAD, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  int unsigned m_idx = 0;
  int unsigned m_cnt = 0;
  logic [31:0] m_word = '0;

  task automatic model_reset();
    m_state = M_IDLE;
    m_idx   = 0;
    m_cnt   = 0;
    m_word  = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_state)
      M_IDLE, M_DONE: if (b == 8'hFE) begin
        m_state = M_LOAD; m_idx = 0; m_cnt = 0;
      end
      M_LOAD: begin
        if (m_idx == 0 && b == 8'hFF) m_state = M_DONE;
        else begin
          m_word[8*m_idx +: 8] = b;
          if (m_idx == 3 && m_cnt < DEPTH) begin
            sb.push_back('{addr: ADDR_W'(m_cnt), data: m_word});
            m_cnt++;
          end
          m_idx = (m_idx + 1) % 4;
        end
      end
      default: ;
    endcase
  endtask

  // Cycle counter and write monitor
  int unsigned cyc = 0;
  int unsigned n_strobes = 0;
  int unsigned strobe_cyc[$];
  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!reset && imem_we_o) begin
      n_strobes++;
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(imem_addr_o), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr_o), 32'(e.addr));
        chk("wr_data", imem_data_o, e.data);
      end
    end
  end

  // Drive one byte, let it be sampled, then settle just after the edge
  task automatic step(input logic [7:0] b);
    @(negedge clk_i);
    instr_i = b;
    model_byte(b);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    instr_i = 8'h00;
    reset = 1'b1;
    model_reset();
    sb.delete();
    #2;
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) step(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[7:0] = 8'($urandom_range(0, 254));
    return w;
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       we;
    logic       ld;
    logic       run;
    logic [6:0] cnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Basic stream 00,00,FE,13,05,A0,00,FF,00 with per-cycle expectations
    tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[2] = '{8'hFE, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[3] = '{8'h13, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[4] = '{8'h05, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[5] = '{8'hA0, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 7'd1};
    tbl[7] = '{8'hFF, 1'b0, 1'b0, 1'b1, 7'd1};
    tbl[8] = '{8'h00, 1'b0, 1'b0, 1'b1, 7'd1};

    // Reset state
    reset = 1'b1;
    #3;
    chk("rst_we",   32'(imem_we_o),   32'd0);
    chk("rst_addr", 32'(imem_addr_o), 32'd0);
    chk("rst_data", imem_data_o,      32'd0);
    chk("rst_cnt",  32'(word_cnt_o),  32'd0);
    chk("rst_ovf",  32'(overflow_o),  32'd0);
    chk("rst_ld",   32'(loading_o),   32'd0);
    chk("rst_run",  32'(core_run_o),  32'd0);
    @(negedge clk_i);
    reset = 1'b0;

    for (int unsigned i = 0; i < 9; i++) begin
      step(tbl[i].b);
      chk($sformatf("tbl%0d_we", i),  32'(imem_we_o),  32'(tbl[i].we));
      chk($sformatf("tbl%0d_ld", i),  32'(loading_o),  32'(tbl[i].ld));
      chk($sformatf("tbl%0d_run", i), 32'(core_run_o), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_cnt", i), 32'(word_cnt_o), 32'(tbl[i].cnt));
    end
    chk("hold_addr", 32'(imem_addr_o), 32'd0);
    chk("hold_data", imem_data_o, 32'h00A00513);

    // Three back-to-back words: strobes 4 cycles apart
    do_reset();
    strobe_cyc.delete();
    step(8'hFE);
    for (int unsigned w = 0; w < 3; w++) send_word(rand_word());
    step(8'hFF);
    step(8'h00);
    chk("b2b_nstrobe", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("b2b_gap01", strobe_cyc[1] - strobe_cyc[0], 32'd4);
      chk("b2b_gap12", strobe_cyc[2] - strobe_cyc[1], 32'd4);
    end
    chk("b2b_cnt", 32'(word_cnt_o), 32'd3);
    chk("b2b_run", 32'(core_run_o), 32'd1);

    // END at byte_idx 0 terminates immediately
    do_reset();
    step(8'hFE);
    step(8'hFF);
    chk("endimm_run", 32'(core_run_o), 32'd1);
    chk("endimm_cnt", 32'(word_cnt_o), 32'd0);
    step(8'hFE);
    step(8'hFF);
    chk("endimm2_run", 32'(core_run_o), 32'd1);

    // FE/FF as data at byte_idx 1..3
    do_reset();
    step(8'hFE); step(8'h13); step(8'hFF); step(8'hFE); step(8'h00);
    chk("mark_data", imem_data_o, 32'h00FEFF13);
    step(8'hFF);
    chk("mark_run", 32'(core_run_o), 32'd1);
    chk("mark_cnt", 32'(word_cnt_o), 32'd1);

    // Overflow: 65 words into 64-entry memory
    do_reset();
    n_strobes = 0;
    step(8'hFE);
    for (int unsigned w = 0; w < 65; w++) send_word(rand_word());
    chk("ovf_flag_pre", 32'(overflow_o), 32'd1);
    chk("ovf_ld_pre",   32'(loading_o),  32'd1);
    step(8'hFF);
    step(8'h00);
    chk("ovf_nstrobe", n_strobes, 32'd64);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_cnt",  32'(word_cnt_o), 32'd64);
    chk("ovf_run",  32'(core_run_o), 32'd1);

    // Asynchronous reset mid-word, after one word has been written
    do_reset();
    step(8'hFE);
    send_word(32'h44332211);
    step(8'h13);
    step(8'h05);
    chk("pre_arst_cnt", 32'(word_cnt_o), 32'd1);
    chk("pre_arst_sb", 32'(sb.size()), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we",   32'(imem_we_o),   32'd0);
    chk("arst_addr", 32'(imem_addr_o), 32'd0);
    chk("arst_data", imem_data_o,      32'd0);
    chk("arst_cnt",  32'(word_cnt_o),  32'd0);
    chk("arst_ovf",  32'(overflow_o),  32'd0);
    chk("arst_ld",   32'(loading_o),   32'd0);
    chk("arst_run",  32'(core_run_o),  32'd0);
    model_reset();
    @(negedge clk_i);
    reset = 1'b0;
    step(8'hFE); step(8'hAA); step(8'hBB); step(8'hCC); step(8'hDD);
    chk("arst_word", imem_data_o, 32'hDDCCBBAA);
    chk("arst_waddr", 32'(imem_addr_o), 32'd0);
    step(8'hFF);
    chk("arst_done", 32'(core_run_o), 32'd1);

    // Re-arm from DONE with two words loaded
    do_reset();
    step(8'hFE);
    send_word(rand_word());
    send_word(rand_word());
    step(8'hFF);
    step(8'h37);
    chk("stray_run", 32'(core_run_o), 32'd1);
    chk("stray_cnt", 32'(word_cnt_o), 32'd2);
    chk("stray_ld",  32'(loading_o),  32'd0);
    step(8'hFE);
    chk("rearm_run", 32'(core_run_o), 32'd0);
    chk("rearm_ld",  32'(loading_o),  32'd1);
    chk("rearm_cnt", 32'(word_cnt_o), 32'd0);
    send_word(32'hCAFE0013);
    chk("rearm_addr", 32'(imem_addr_o), 32'd0);
    step(8'hFF);
    step(8'h00);
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
